// File: rtl/muldiv_hilo_ctrl.sv
// muldiv_hilo_ctrl: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO.
// Operand magnitudes are processed unsigned for 32 steps. The signs are
// re-applied in FIX, and the result is committed to HI/LO when leaving FIX.
// Optional build macro: MULDIV_EARLY_OUT_EN lets multiplies leave RUN as soon
// as the remaining multiplier bits are zero. FIX then realigns the product.
module muldiv_hilo_ctrl (
    input  logic        Clk,
    input  logic        Rst,
    input  logic        start,
    input  logic [1:0]  op,
    input  logic [31:0] src_a,
    input  logic [31:0] src_b,
    input  logic        flush,
    input  logic        hilo_read,
    input  logic        hilo_wr,
    input  logic        hilo_wr_sel,
    input  logic [31:0] hilo_wr_data,
    output logic        busy,
    output logic        stall,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        done,
    output logic        div_zero
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_FIX  = 2'd2
    } state_t;

    state_t      state_q;
    logic [5:0]  cnt_q;
    logic [63:0] acc_q;
    logic [31:0] opa_q;
    logic [31:0] opb_q;
    logic        isDiv_q;
    logic        negQ_q;
    logic        negR_q;
    logic        dz_q;
    logic [31:0] hi_q;
    logic [31:0] lo_q;
    logic        busy_q;
    logic        done_q;
    logic        divZero_q;

    logic [31:0] magA_d;
    logic [31:0] magB_d;
    logic [32:0] mulSum_d;
    logic [63:0] mulAcc_d;
    logic [32:0] divTrial_d;
    logic        divOk_d;
    logic [63:0] divAcc_d;
    logic [63:0] stepAcc_d;
    logic        leaveRun_d;
    logic [63:0] prodAligned_d;
    logic [63:0] prod_d;
    logic [31:0] quot_d;
    logic [31:0] rem_d;
    logic [63:0] result_d;

`ifdef MULDIV_EARLY_OUT_EN
    logic [5:0]  shAmt_d;
`endif

    // Operand magnitudes, one iteration step, and the signed fix-up of the finished result
    always_comb begin
        magA_d = (op[0] && src_a[31]) ? (~src_a + 32'd1) : src_a;
        magB_d = (op[0] && src_b[31]) ? (~src_b + 32'd1) : src_b;

        // Shift-add: add the multiplicand into the top half, then shift the whole accumulator right
        mulSum_d = {1'b0, acc_q[63:32]} + (opb_q[0] ? {1'b0, opa_q} : 33'd0);
        mulAcc_d = {mulSum_d, acc_q[31:1]};

        // Restoring divide: bring in the next dividend bit and keep the difference only if it did not borrow
        divTrial_d = {acc_q[63:32], opa_q[31]} - {1'b0, opb_q};
        divOk_d    = ~divTrial_d[32];
        divAcc_d   = {(divOk_d ? divTrial_d[31:0] : {acc_q[62:32], opa_q[31]}),
                      acc_q[30:0], divOk_d};

        stepAcc_d = isDiv_q ? divAcc_d : mulAcc_d;

`ifdef MULDIV_EARLY_OUT_EN
        leaveRun_d    = (cnt_q == 6'd31) || (!isDiv_q && (opb_q[31:1] == 31'd0));
        shAmt_d       = 6'd32 - cnt_q;
        prodAligned_d = acc_q >> shAmt_d;
`else
        leaveRun_d    = (cnt_q == 6'd31);
        prodAligned_d = acc_q;
`endif

        prod_d = negQ_q ? (~prodAligned_d + 64'd1) : prodAligned_d;
        quot_d = negQ_q ? (~acc_q[31:0] + 32'd1) : acc_q[31:0];
        rem_d  = negR_q ? (~acc_q[63:32] + 32'd1) : acc_q[63:32];

        if (dz_q) begin
            result_d = acc_q;
        end else if (isDiv_q) begin
            result_d = {rem_d, quot_d};
        end else begin
            result_d = prod_d;
        end
    end

    // Sequencer FSM with the datapath registers, HI/LO ownership and registered status outputs
    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q   <= S_IDLE;
            cnt_q     <= 6'd0;
            acc_q     <= 64'd0;
            opa_q     <= 32'd0;
            opb_q     <= 32'd0;
            isDiv_q   <= 1'b0;
            negQ_q    <= 1'b0;
            negR_q    <= 1'b0;
            dz_q      <= 1'b0;
            hi_q      <= 32'd0;
            lo_q      <= 32'd0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            divZero_q <= 1'b0;
        end else begin
            done_q    <= 1'b0;
            divZero_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start && !flush) begin
                        opa_q   <= magA_d;
                        opb_q   <= magB_d;
                        isDiv_q <= op[1];
                        cnt_q   <= 6'd0;
                        busy_q  <= 1'b1;
                        if (op[1] && (src_b == 32'd0)) begin
                            // A zero divisor skips the loop; the raw result is parked in the accumulator
                            state_q <= S_FIX;
                            dz_q    <= 1'b1;
                            negQ_q  <= 1'b0;
                            negR_q  <= 1'b0;
                            acc_q   <= {src_a, 32'hFFFF_FFFF};
                        end else begin
                            state_q <= S_RUN;
                            dz_q    <= 1'b0;
                            negQ_q  <= op[0] & (src_a[31] ^ src_b[31]);
                            negR_q  <= op[0] & src_a[31];
                            acc_q   <= 64'd0;
                        end
                    end
                end
                S_RUN: begin
                    if (flush || hilo_wr) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        acc_q <= stepAcc_d;
                        cnt_q <= cnt_q + 6'd1;
                        if (isDiv_q) begin
                            opa_q <= {opa_q[30:0], 1'b0};
                        end else begin
                            opb_q <= {1'b0, opb_q[31:1]};
                        end
                        if (leaveRun_d) begin
                            state_q <= S_FIX;
                        end
                    end
                end
                S_FIX: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                    if (!flush) begin
                        hi_q      <= result_d[63:32];
                        lo_q      <= result_d[31:0];
                        done_q    <= 1'b1;
                        divZero_q <= dz_q;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
            // A WB write lands last so it overrides a commit made at the same edge
            if (hilo_wr) begin
                if (hilo_wr_sel) begin
                    hi_q <= hilo_wr_data;
                end else begin
                    lo_q <= hilo_wr_data;
                end
            end
        end
    end

    assign busy     = busy_q;
    assign stall    = busy_q & (start | hilo_read);
    assign hi       = hi_q;
    assign lo       = lo_q;
    assign done     = done_q;
    assign div_zero = divZero_q;

endmodule

// File: tb/tb_muldiv_hilo_ctrl.sv
// tb_muldiv_hilo_ctrl: scoreboard bench for muldiv_hilo_ctrl.
// The stimulus pushes expected HI/LO/div_zero and completion cycle computed
// with plain 64-bit arithmetic. A monitor pops one entry on every done pulse.
module tb_muldiv_hilo_ctrl;

    logic        Clk = 1'b0;
    logic        Rst;
    logic        start;
    logic [1:0]  op;
    logic [31:0] src_a;
    logic [31:0] src_b;
    logic        flush;
    logic        hilo_read;
    logic        hilo_wr;
    logic        hilo_wr_sel;
    logic [31:0] hilo_wr_data;
    logic        busy;
    logic        stall;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        done;
    logic        div_zero;

    typedef struct {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        dz;
        int          cyc;
    } exp_t;

    exp_t        sb[$];
    int          total = 0;
    int          bad = 0;
    int          cyc = 0;
    logic [31:0] expHi = 32'd0;
    logic [31:0] expLo = 32'd0;

    muldiv_hilo_ctrl dut (
        .Clk          (Clk),
        .Rst          (Rst),
        .start        (start),
        .op           (op),
        .src_a        (src_a),
        .src_b        (src_b),
        .flush        (flush),
        .hilo_read    (hilo_read),
        .hilo_wr      (hilo_wr),
        .hilo_wr_sel  (hilo_wr_sel),
        .hilo_wr_data (hilo_wr_data),
        .busy         (busy),
        .stall        (stall),
        .hi           (hi),
        .lo           (lo),
        .done         (done),
        .div_zero     (div_zero)
    );

    // Free-running clock and cycle number
    always #5 Clk = ~Clk;

    always @(posedge Clk) cyc <= cyc + 1;

    // Reference result {HI, LO} from plain integer arithmetic
    function automatic logic [63:0] refResult(logic [1:0] o, logic [31:0] a, logic [31:0] b);
        longint      sa;
        longint      sb2;
        longint      q;
        longint      r;
        logic [63:0] res;
        sa  = longint'($signed(a));
        sb2 = longint'($signed(b));
        if (o == 2'b00) begin
            res = {32'd0, a} * {32'd0, b};
        end else if (o == 2'b01) begin
            res = sa * sb2;
        end else if (b == 32'd0) begin
            res = {a, 32'hFFFF_FFFF};
        end else if (o == 2'b10) begin
            res = {a % b, a / b};
        end else begin
            q   = sa / sb2;
            r   = sa % sb2;
            res = {r[31:0], q[31:0]};
        end
        return res;
    endfunction

    // Cycles from the start cycle to the done cycle
    function automatic int latencyOf(logic [1:0] o, logic [31:0] b);
        int          n;
        logic [31:0] m;
        n = 34;
        m = (o[0] && b[31]) ? -b : b;
        if (o[1] && (b == 32'd0)) begin
            n = 2;
        end
`ifdef MULDIV_EARLY_OUT_EN
        else if (!o[1]) begin
            n = 1;
            for (int i = 0; i < 32; i++) begin
                if (m[i]) n = i + 1;
            end
            n = n + 2;
        end
`endif
        return n;
    endfunction

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("[TB] FAIL %s: got %h expected %h", name, act, want);
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        #1;
    endtask

    // Start pulse in the current cycle; optionally record the expected completion
    task automatic applyStimulus(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b, input bit doPush);
        logic [63:0] r;
        exp_t        e;
        r     = refResult(o, a, b);
        op    = o;
        src_a = a;
        src_b = b;
        start = 1'b1;
        if (doPush) begin
            e.hi  = r[63:32];
            e.lo  = r[31:0];
            e.dz  = o[1] && (b == 32'd0);
            e.cyc = cyc + latencyOf(o, b);
            sb.push_back(e);
            expHi = r[63:32];
            expLo = r[31:0];
        end
        tick();
        start = 1'b0;
    endtask

    // Issue an operation and return in its done cycle, ready for a back-to-back start
    task automatic runOp(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        int lat;
        lat = latencyOf(o, b);
        applyStimulus(o, a, b, 1'b1);
        repeat (lat - 1) tick();
    endtask

    // Monitor: every done pulse must match the oldest expected completion
    always @(negedge Clk) begin
        exp_t e;
        if (!Rst && done) begin
            if (sb.size() == 0) begin
                total++;
                bad++;
                $display("[TB] FAIL spurious_done: got done=1 at cycle %0d expected none", cyc);
            end else begin
                e = sb.pop_front();
                checkOutput("hi", {32'd0, hi}, {32'd0, e.hi});
                checkOutput("lo", {32'd0, lo}, {32'd0, e.lo});
                checkOutput("div_zero", {63'd0, div_zero}, {63'd0, e.dz});
                checkOutput("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        int          n0;
        logic [63:0] r;
        logic [31:0] d;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;
        exp_t        e;

        Rst = 1'b1; start = 1'b0; op = 2'b00; src_a = 32'd0; src_b = 32'd0;
        flush = 1'b0; hilo_read = 1'b0; hilo_wr = 1'b0; hilo_wr_sel = 1'b0; hilo_wr_data = 32'd0;
        repeat (3) @(posedge Clk);
        #1 Rst = 1'b0;

        // Reset state
        @(negedge Clk);
        checkOutput("rst_hi", {32'd0, hi}, 64'd0);
        checkOutput("rst_lo", {32'd0, lo}, 64'd0);
        checkOutput("rst_busy", {63'd0, busy}, 64'd0);
        checkOutput("rst_stall", {63'd0, stall}, 64'd0);
        checkOutput("rst_done", {63'd0, done}, 64'd0);
        tick();

        // Reset in the middle of RUN aborts without a done
        applyStimulus(2'b00, $urandom, $urandom | 32'd1, 1'b0);
        repeat (4) tick();
        Rst = 1'b1;
        @(negedge Clk);
        checkOutput("midrst_busy", {63'd0, busy}, 64'd0);
        checkOutput("midrst_hi", {32'd0, hi}, 64'd0);
        checkOutput("midrst_lo", {32'd0, lo}, 64'd0);
        @(posedge Clk);
        #1 Rst = 1'b0;
        tick();

        // MULT -1 x 2 with the busy window traced cycle by cycle
        n0 = cyc;
        applyStimulus(2'b01, 32'hFFFF_FFFF, 32'd2, 1'b1);
        for (int k = 1; k < latencyOf(2'b01, 32'd2); k++) begin
            @(negedge Clk);
            checkOutput("busy_window", {63'd0, busy}, 64'd1);
            tick();
        end
        @(negedge Clk);
        checkOutput("busy_after", {63'd0, busy}, 64'd0);
        tick();

        // Directed divides, including zero divisor and signed overflow
        runOp(2'b11, 32'hFFFF_FFF9, 32'd2);
        runOp(2'b10, 32'd7, 32'd0);
        runOp(2'b11, 32'h8000_0000, 32'hFFFF_FFFF);
        runOp(2'b10, 32'd100, 32'd7);
        runOp(2'b00, 32'd3, 32'd5);
        runOp(2'b11, 32'd9, 32'd0);

        // MFHI interlock; an ignored start while busy must not cause an extra done
        n0 = cyc;
        applyStimulus(2'b00, 32'h0001_0003, 32'h8000_0001, 1'b1);
        repeat (3) tick();
        @(negedge Clk);
        checkOutput("stall_indep", {63'd0, stall}, 64'd0);
        tick();
        hilo_read = 1'b1;
        for (int c = 5; c <= 34; c++) begin
            start = (c == 7);
            if (c == 7) begin
                op = 2'b10; src_a = 32'd55; src_b = 32'd0;
            end
            @(negedge Clk);
            checkOutput("stall_mfhi", {63'd0, stall}, (cyc < n0 + latencyOf(2'b00, 32'h8000_0001)) ? 64'd1 : 64'd0);
            tick();
        end
        hilo_read = 1'b0;
        start = 1'b0;
        repeat (3) tick();

        // Flush mid-RUN: idle next cycle, HI/LO untouched, no done
        applyStimulus(2'b00, $urandom, 32'hFFFF_FFFF, 1'b0);
        repeat (8) tick();
        flush = 1'b1;
        tick();
        flush = 1'b0;
        @(negedge Clk);
        checkOutput("flush_busy", {63'd0, busy}, 64'd0);
        checkOutput("flush_hi", {32'd0, hi}, {32'd0, expHi});
        checkOutput("flush_lo", {32'd0, lo}, {32'd0, expLo});
        repeat (36) tick();

        // MTLO while busy aborts and writes
        applyStimulus(2'b00, $urandom, 32'hFFFF_FFFF, 1'b0);
        repeat (8) tick();
        hilo_wr = 1'b1; hilo_wr_sel = 1'b0; hilo_wr_data = 32'h0000_1234;
        tick();
        hilo_wr = 1'b0;
        expLo = 32'h0000_1234;
        @(negedge Clk);
        checkOutput("mtlo_busy", {63'd0, busy}, 64'd0);
        checkOutput("mtlo_lo", {32'd0, lo}, {32'd0, expLo});
        checkOutput("mtlo_hi", {32'd0, hi}, {32'd0, expHi});
        repeat (36) tick();

        // MTHI while idle
        d = $urandom;
        hilo_wr = 1'b1; hilo_wr_sel = 1'b1; hilo_wr_data = d;
        tick();
        hilo_wr = 1'b0;
        @(negedge Clk);
        checkOutput("mthi_idle", {32'd0, hi}, {32'd0, d});
        tick();

        // MTHI in the FIX cycle overrides the committed HI, done still pulses
        a = $urandom; b = $urandom | 32'h0000_0100;
        r = refResult(2'b01, a, b);
        n0 = cyc;
        applyStimulus(2'b01, a, b, 1'b0);
        repeat (latencyOf(2'b01, b) - 2) tick();
        d = $urandom;
        e.hi = d; e.lo = r[31:0]; e.dz = 1'b0; e.cyc = n0 + latencyOf(2'b01, b);
        sb.push_back(e);
        expHi = d; expLo = r[31:0];
        hilo_wr = 1'b1; hilo_wr_sel = 1'b1; hilo_wr_data = d;
        tick();
        hilo_wr = 1'b0;

        // Randomized back-to-back operations
        for (int i = 0; i < 24; i++) begin
            o = 2'($urandom_range(0, 3));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 5))
                0: b = 32'd0;
                1: b = 32'($urandom_range(1, 300));
                2: a = 32'($urandom_range(0, 1000));
                default: ;
            endcase
            runOp(o, a, b);
        end

        repeat (5) tick();
        checkOutput("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
